// File: rtl/sc_game_timebase.sv
`timescale 1ns/1ps
// Countdown timer (IDLE/RUN/DONE) and speed-tick pacer for the game FSM.
// All outputs are registered; the loaded value appears on count one cycle after the load edge.
module sc_game_timebase #(
    parameter int PRESCALE_TICKS   = 50_000_000,
    parameter int SPEED_BASE_TICKS = 5_000_000
) (
    input  logic       SC_STATEMACHINE_GENERAL_CLOCK_50,
    input  logic       SC_STATEMACHINE_GENERAL_RESET_InHigh,
    input  logic       timer_load_InLow,
    input  logic [7:0] timer_value_InBUS,
    input  logic       speed_clear_InLow,
    input  logic [3:0] speed_limit_InBUS,
    output logic       timer_done_OutLow,
    output logic [7:0] timer_count_OutBUS,
    output logic       speed_tick_OutLow,
    output logic       timer_busy_OutHigh
);

    localparam int PW = (PRESCALE_TICKS > 1) ? $clog2(PRESCALE_TICKS) : 1;
    localparam int BW = (SPEED_BASE_TICKS > 1) ? $clog2(SPEED_BASE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_TICKS - 1);
    localparam logic [BW-1:0] BASE_LAST  = BW'(SPEED_BASE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] div_q, div_d;
    logic [3:0]    spd_q, spd_d;
    logic          tick_q, tick_d;
    logic [3:0]    limit_eff;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        if (!timer_load_InLow) begin
            // Load wins over a coincident prescaler terminal.
            count_d = timer_value_InBUS;
            presc_d = '0;
            state_d = (timer_value_InBUS != 8'd0) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        count_d = count_q - 8'd1;
                        if (count_q == 8'd1) state_d = DONE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE:    count_d = 8'd0;
                default: ;
            endcase
        end
        done_d = (state_d != DONE);
        busy_d = (state_d == RUN);
    end

    always_comb begin
        limit_eff = (speed_limit_InBUS == 4'd0) ? 4'd1 : speed_limit_InBUS;
        div_d     = div_q;
        spd_d     = spd_q;
        tick_d    = 1'b1;
        if (!speed_clear_InLow) begin
            div_d = '0;
            spd_d = 4'd0;
        end else if (div_q == BASE_LAST) begin
            div_d = '0;
            // >= so a limit lowered below the running count fires immediately.
            if ({1'b0, spd_q} + 5'd1 >= {1'b0, limit_eff}) begin
                spd_d  = 4'd0;
                tick_d = 1'b0;
            end else begin
                spd_d = spd_q + 4'd1;
            end
        end else begin
            div_d = div_q + BW'(1);
        end
    end

    always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            presc_q <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            div_q   <= '0;
            spd_q   <= 4'd0;
            tick_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            div_q   <= div_d;
            spd_q   <= spd_d;
            tick_q  <= tick_d;
        end
    end

    assign timer_done_OutLow  = done_q;
    assign timer_count_OutBUS = count_q;
    assign speed_tick_OutLow  = tick_q;
    assign timer_busy_OutHigh = busy_q;

endmodule

// File: tb/tb_sc_game_timebase.sv
`timescale 1ns/1ps
// Directed bench for sc_game_timebase with PRESCALE_TICKS=4, SPEED_BASE_TICKS=2.
module tb_sc_game_timebase;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_n = 1'b1;
    logic [7:0] value = 8'd0;
    logic       clear_n = 1'b0;
    logic [3:0] limit = 4'd3;
    logic       done_n;
    logic [7:0] count;
    logic       tick_n;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sc_game_timebase #(.PRESCALE_TICKS(4), .SPEED_BASE_TICKS(2)) dut (
        .SC_STATEMACHINE_GENERAL_CLOCK_50     (clk),
        .SC_STATEMACHINE_GENERAL_RESET_InHigh (rst),
        .timer_load_InLow                     (load_n),
        .timer_value_InBUS                    (value),
        .speed_clear_InLow                    (clear_n),
        .speed_limit_InBUS                    (limit),
        .timer_done_OutLow                    (done_n),
        .timer_count_OutBUS                   (count),
        .speed_tick_OutLow                    (tick_n),
        .timer_busy_OutHigh                   (busy)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        step(3);
        chk("rst_done", {7'd0, done_n}, 8'd1);
        chk("rst_tick", {7'd0, tick_n}, 8'd1);
        chk("rst_count", count, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;
        step(2);

        // Load 3: count 3, 2 at +4, 1 at +8, 0 and done at +12.
        load_n = 1'b0; value = 8'd3;
        step(1);
        load_n = 1'b1;
        chk("t2_count3", count, 8'd3);
        chk("t2_busy", {7'd0, busy}, 8'd1);
        chk("t2_done_hi", {7'd0, done_n}, 8'd1);
        step(4);
        chk("t2_count2", count, 8'd2);
        step(4);
        chk("t2_count1", count, 8'd1);
        step(3);
        chk("t2_count1_late", count, 8'd1);
        chk("t2_done_late", {7'd0, done_n}, 8'd1);
        step(1);
        chk("t2_count0", count, 8'd0);
        chk("t2_done", {7'd0, done_n}, 8'd0);
        chk("t2_busy_off", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t2_done_hold", {7'd0, done_n}, 8'd0);
        end

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("arst_done", {7'd0, done_n}, 8'd1);
        chk("arst_count", count, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_tick", {7'd0, tick_n}, 8'd1);
        step(1);
        rst = 1'b0;
        step(1);

        // Zero-length load goes straight to DONE.
        load_n = 1'b0; value = 8'd0;
        step(1);
        load_n = 1'b1;
        chk("t3_done", {7'd0, done_n}, 8'd0);
        chk("t3_busy", {7'd0, busy}, 8'd0);
        chk("t3_count", count, 8'd0);

        // Load 5, reload 2 when count reaches 1.
        load_n = 1'b0; value = 8'd5;
        step(1);
        load_n = 1'b1;
        chk("t4_count5", count, 8'd5);
        step(16);
        chk("t4_count1", count, 8'd1);
        load_n = 1'b0; value = 8'd2;
        step(1);
        load_n = 1'b1;
        chk("t4_reload", count, 8'd2);
        chk("t4_done_hi", {7'd0, done_n}, 8'd1);
        step(7);
        chk("t4_done_pre", {7'd0, done_n}, 8'd1);
        step(1);
        chk("t4_done", {7'd0, done_n}, 8'd0);

        // Reload coincident with prescaler terminal while count=1.
        load_n = 1'b0; value = 8'd2;
        step(1);
        load_n = 1'b1;
        step(4);
        chk("t6_count1", count, 8'd1);
        step(3);
        load_n = 1'b0; value = 8'd3;
        step(1);
        load_n = 1'b1;
        chk("t6_count3", count, 8'd3);
        chk("t6_done_hi", {7'd0, done_n}, 8'd1);
        chk("t6_busy", {7'd0, busy}, 8'd1);
        step(11);
        chk("t6_done_pre", {7'd0, done_n}, 8'd1);
        step(1);
        chk("t6_done", {7'd0, done_n}, 8'd0);

        // Speed: limit=3 -> tick every 6 clocks after clear release.
        limit = 4'd3;
        clear_n = 1'b1;
        step(5);
        chk("t5_tick_pre", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t5_tick1", {7'd0, tick_n}, 8'd0);
        step(1);
        chk("t5_tick1_end", {7'd0, tick_n}, 8'd1);
        step(4);
        chk("t5_tick2_pre", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t5_tick2", {7'd0, tick_n}, 8'd0);
        // Clear pulsed 4 cycles into the period restarts it.
        step(3);
        clear_n = 1'b0;
        step(1);
        clear_n = 1'b1;
        chk("t5_clr_tick", {7'd0, tick_n}, 8'd1);
        step(5);
        chk("t5_clr_pre", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t5_clr_tick6", {7'd0, tick_n}, 8'd0);
        // limit=0 behaves as 1: tick every 2 clocks.
        limit = 4'd0;
        step(1);
        chk("t5_l0_a", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t5_l0_b", {7'd0, tick_n}, 8'd0);
        step(1);
        chk("t5_l0_c", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t5_l0_d", {7'd0, tick_n}, 8'd0);
        // Clear coincident with a would-be tick suppresses it.
        step(1);
        clear_n = 1'b0;
        step(1);
        clear_n = 1'b1;
        chk("t6_clr_wins", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t6_after_clr", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("t6_next_tick", {7'd0, tick_n}, 8'd0);

        // Lowering limit below running count fires at next base terminal.
        clear_n = 1'b0; limit = 4'd5;
        step(1);
        clear_n = 1'b1;
        step(6);
        chk("lower_no_tick", {7'd0, tick_n}, 8'd1);
        limit = 4'd2;
        step(1);
        chk("lower_mid", {7'd0, tick_n}, 8'd1);
        step(1);
        chk("lower_fire", {7'd0, tick_n}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
